wd_apb_timer: RTL and testbench

Two-stage watchdog timer with an 8-bit APB slave register port. It is the responder side of the APB bus driven by the testbench bus-functional model: it decodes `psel`/`penable`/`pwrite` accesses, holds the control, reload and prescale registers, and drives `prdata`, `intr` and `timeout` back to the bench. A missed kick first raises `intr`; a second consecutive expiry raises `timeout`.

---
 rtl/wd_apb_timer.sv | 164 ++++++++++++++++
 tb/tb_wd_apb_timer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wd_apb_timer.sv
// wd_apb_timer -- two-stage watchdog timer behind an 8-bit APB slave port.
//
// The counter runs down once per prescaler tick. A missed kick, meaning the
// counter hits zero and ticks again, sets IFLAG and raises intr when IEN is
// set. If IFLAG is still set on the next expiry, TFLAG sets and drives the
// sticky timeout output.
//
// Register map (byte addresses):
//   0x00 CTRL     rw  bit0 EN, bit1 IEN
//   0x04 LOAD     rw  reload value, used at the next reload only
//   0x08 COUNT    ro  current counter value
//   0x0C KICK     wo  writing KICK_KEY reloads COUNT and clears the prescaler
//   0x10 STATUS   w1c bit0 IFLAG, bit1 TFLAG
//   0x14 PRESCALE rw  one tick every PRESCALE+1 enabled cycles
//
// Ports:
//   pclk     clock, rising edge
//   preset   synchronous active-high reset
//   psel, penable, pwrite, paddr[7:0], pwdata[7:0]  APB request (no wait states)
//   prdata[7:0]  combinational read data, 0x00 when no read is selected
//   intr     IFLAG & IEN
//   timeout  TFLAG, sticky until cleared or reset
module wd_apb_timer #(
  parameter logic [7:0] LOAD_RST     = 8'hFF,
  parameter logic [7:0] PRESCALE_RST = 8'h00,
  parameter logic [7:0] KICK_KEY     = 8'h5A
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       intr,
  output logic       timeout
);

  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_LOAD     = 8'h04;
  localparam logic [7:0] ADDR_COUNT    = 8'h08;
  localparam logic [7:0] ADDR_KICK     = 8'h0C;
  localparam logic [7:0] ADDR_STATUS   = 8'h10;
  localparam logic [7:0] ADDR_PRESCALE = 8'h14;

  // Architectural state
  logic       en_q, ien_q;
  logic [7:0] load_q, presc_q, count_q, pcnt_q;
  logic       iflag_q, tflag_q;

  // Next-state values
  logic       en_d, ien_d;
  logic [7:0] load_d, presc_d, count_d, pcnt_d;
  logic       iflag_d, tflag_d;

  // Access decode
  logic wr_commit;
  logic ctrl_wr, load_wr, kick_wr, status_wr, presc_wr;
  logic en_rise, run, expire;

  assign wr_commit = psel & penable & pwrite;
  assign ctrl_wr   = wr_commit && (paddr == ADDR_CTRL);
  assign load_wr   = wr_commit && (paddr == ADDR_LOAD);
  assign kick_wr   = wr_commit && (paddr == ADDR_KICK) && (pwdata == KICK_KEY);
  assign status_wr = wr_commit && (paddr == ADDR_STATUS);
  assign presc_wr  = wr_commit && (paddr == ADDR_PRESCALE);

  // EN going 0->1 restarts the count from LOAD.
  assign en_rise = ctrl_wr & pwdata[0] & ~en_q;
  // A CTRL write that clears EN stops the timer on that very edge, so a tick
  // falling on the same edge is suppressed.
  assign run     = en_q & ~(ctrl_wr & ~pwdata[0]);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch can be inferred.
    en_d    = en_q;
    ien_d   = ien_q;
    load_d  = load_q;
    presc_d = presc_q;
    count_d = count_q;
    pcnt_d  = pcnt_q;
    iflag_d = iflag_q;
    tflag_d = tflag_q;
    expire  = 1'b0;

    if (ctrl_wr) begin
      en_d  = pwdata[0];
      ien_d = pwdata[1];
    end
    if (load_wr)  load_d  = pwdata;
    if (presc_wr) presc_d = pwdata;

    // Reloads sample the LOAD value held before this edge, so a LOAD write
    // only matters at the following reload. A kick beats a same-edge expiry.
    if (kick_wr || en_rise) begin
      count_d = load_q;
      pcnt_d  = 8'h00;
    end else if (!run) begin
      pcnt_d  = 8'h00;
    end else if (pcnt_q == presc_q) begin
      pcnt_d = 8'h00;
      if (count_q == 8'h00) begin
        expire  = 1'b1;
        count_d = load_q;
      end else begin
        count_d = count_q - 8'h01;
      end
    end else begin
      pcnt_d = pcnt_q + 8'h01;
    end

    // Write-1-to-clear first, then a same-edge set overrides the clear.
    // The first expiry lands in IFLAG, a repeat while IFLAG is pending in TFLAG.
    if (status_wr && pwdata[0]) iflag_d = 1'b0;
    if (status_wr && pwdata[1]) tflag_d = 1'b0;
    if (expire && !iflag_q) iflag_d = 1'b1;
    if (expire && iflag_q)  tflag_d = 1'b1;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge pclk) begin
    if (preset) begin
      en_q    <= 1'b0;
      ien_q   <= 1'b0;
      load_q  <= LOAD_RST;
      presc_q <= PRESCALE_RST;
      count_q <= LOAD_RST;
      pcnt_q  <= 8'h00;
      iflag_q <= 1'b0;
      tflag_q <= 1'b0;
    end else begin
      en_q    <= en_d;
      ien_q   <= ien_d;
      load_q  <= load_d;
      presc_q <= presc_d;
      count_q <= count_d;
      pcnt_q  <= pcnt_d;
      iflag_q <= iflag_d;
      tflag_q <= tflag_d;
    end
  end

  // Read data is a pure decode of paddr during any read-selected cycle.
  always_comb begin
    prdata = 8'h00;
    if (psel && !pwrite) begin
      case (paddr)
        ADDR_CTRL:     prdata = {6'b0, ien_q, en_q};
        ADDR_LOAD:     prdata = load_q;
        ADDR_COUNT:    prdata = count_q;
        ADDR_STATUS:   prdata = {6'b0, tflag_q, iflag_q};
        ADDR_PRESCALE: prdata = presc_q;
        default:       prdata = 8'h00;
      endcase
    end
  end

  assign intr    = iflag_q & ien_q;
  assign timeout = tflag_q;

endmodule

// File: tb/tb_wd_apb_timer.sv
// Testbench for wd_apb_timer: directed scenarios plus randomized APB traffic.
// Expected read data is queued when a read reaches its access phase; expected
// intr/timeout are queued by the reference model after every clock edge. A
// monitor on the falling edge pops and compares both.
module tb_wd_apb_timer;

  localparam logic [7:0] KEY = 8'h5A;

  logic       pclk = 1'b0;
  logic       preset, psel, penable, pwrite;
  logic [7:0] paddr, pwdata, prdata;
  logic       intr, timeout;

  always #5 pclk = ~pclk;

  wd_apb_timer dut (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .intr    (intr),
    .timeout (timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [1:0] flag_q[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, {7'b0, act}, {7'b0, exp});
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. The counter is described by elapsed enabled cycles since
  // the last reload: COUNT = rl - age/(P+1), and an expiry occurs once age
  // reaches (rl+1)*(P+1). Disabling freezes the visible COUNT into rl.
  // ---------------------------------------------------------------------------
  logic       m_en, m_ien, m_if, m_tf;
  logic [7:0] m_load, m_presc;
  int         m_rl, m_age;

  function automatic logic [7:0] m_count();
    return 8'(m_rl - m_age / (int'(m_presc) + 1));
  endfunction

  function automatic logic [7:0] m_read(input logic [7:0] a);
    case (a)
      8'h00:   return {6'b0, m_ien, m_en};
      8'h04:   return m_load;
      8'h08:   return m_count();
      8'h10:   return {6'b0, m_tf, m_if};
      8'h14:   return m_presc;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge pclk) begin : model_proc
    logic wr, expire, old_if;
    if (preset) begin
      m_en = 1'b0; m_ien = 1'b0; m_if = 1'b0; m_tf = 1'b0;
      m_load = 8'hFF; m_presc = 8'h00; m_rl = 255; m_age = 0;
    end else begin
      wr     = psel & penable & pwrite;
      expire = 1'b0;
      old_if = m_if;
      if (wr && paddr == 8'h0C && pwdata == KEY) begin
        m_rl = int'(m_load); m_age = 0;
      end else if (wr && paddr == 8'h00 && pwdata[0] && !m_en) begin
        m_rl = int'(m_load); m_age = 0;
      end else if (wr && paddr == 8'h00 && !pwdata[0] && m_en) begin
        m_rl = int'(m_count()); m_age = 0;
      end else if (m_en) begin
        m_age++;
        if (m_age == (m_rl + 1) * (int'(m_presc) + 1)) begin
          expire = 1'b1;
          m_rl   = int'(m_load);
          m_age  = 0;
        end
      end
      if (wr && paddr == 8'h10) begin
        if (pwdata[0]) m_if = 1'b0;
        if (pwdata[1]) m_tf = 1'b0;
      end
      if (expire) begin
        if (old_if) m_tf = 1'b1;
        else        m_if = 1'b1;
      end
      if (wr && paddr == 8'h00) begin m_en = pwdata[0]; m_ien = pwdata[1]; end
      if (wr && paddr == 8'h04) m_load  = pwdata;
      if (wr && paddr == 8'h14) m_presc = pwdata;
    end
    flag_q.push_back({m_if & m_ien, m_tf});
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge pclk) begin : monitor_proc
    logic [1:0] ef;
    rd_exp_t    e;
    if (flag_q.size() > 0) begin
      ef = flag_q.pop_front();
      check_bit("intr", intr, ef[1]);
      check_bit("timeout", timeout, ef[0]);
    end
    if (psel && penable && !pwrite) begin
      if (rd_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL prdata: unexpected read of %h, got %h, no expected value queued", paddr, prdata);
      end else begin
        e = rd_q.pop_front();
        check($sformatf("prdata@%h", e.addr), prdata, e.data);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bus driver (all tasks start and end 1 time unit after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic bus_idle();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    step();
    penable = 1'b1;
    step();
    bus_idle();
  endtask

  task automatic apb_read(input logic [7:0] a, input logic [7:0] exp, input bit use_model);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    step();
    penable = 1'b1;
    rd_q.push_back('{a, use_model ? m_read(a) : exp});
    step();
    bus_idle();
  endtask

  task automatic read_reset_values();
    apb_read(8'h00, 8'h00, 0);
    apb_read(8'h04, 8'hFF, 0);
    apb_read(8'h08, 8'hFF, 0);
    apb_read(8'h0C, 8'h00, 0);
    apb_read(8'h10, 8'h00, 0);
    apb_read(8'h14, 8'h00, 0);
    apb_read(8'h20, 8'h00, 0);
    check_bit("intr_after_reset", intr, 1'b0);
    check_bit("timeout_after_reset", timeout, 1'b0);
  endtask

  // Stop the timer and clear both flags, keeping IEN set.
  task automatic quiesce();
    apb_write(8'h00, 8'h02);
    apb_write(8'h10, 8'h03);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] cseq[9];
    logic [7:0] addrs[8];
    logic [7:0] d;
    cseq  = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd3, 8'd2, 8'd1, 8'd0, 8'd3};
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h20};

    preset = 1'b1; paddr = 8'h00; pwdata = 8'h00;
    bus_idle();
    step();
    step();
    preset = 1'b0;

    // Reset values
    read_reset_values();

    // PRESCALE=0, LOAD=3, enable with IEN: intr at +4, timeout at +8
    apb_write(8'h04, 8'h03);
    apb_write(8'h00, 8'h03);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b1; paddr = 8'h08;
    for (int k = 0; k < 9; k++) begin
      rd_q.push_back('{8'h08, cseq[k]});
      check_bit("intr_sched", intr, k >= 4);
      check_bit("timeout_sched", timeout, k >= 8);
      step();
    end
    bus_idle();

    // Kicking every 3 cycles keeps intr low for about 100 cycles
    quiesce();
    apb_write(8'h00, 8'h03);
    for (int k = 0; k < 34; k++) begin
      apb_write(8'h0C, KEY);
      check_bit("kick_keeps_intr_low", intr, 1'b0);
      step();
    end

    // A wrong key is ignored, so the expiry stays on schedule
    apb_write(8'h0C, KEY);
    apb_write(8'h0C, 8'h11);
    step();
    check_bit("bad_kick_before_expiry", intr, 1'b0);
    step();
    check_bit("bad_kick_expiry", intr, 1'b1);

    // A kick committed on the expiry edge wins
    quiesce();
    apb_write(8'h00, 8'h03);
    step();
    step();
    apb_write(8'h0C, KEY);
    check_bit("kick_on_expiry_intr", intr, 1'b0);
    apb_read(8'h10, 8'h00, 0);

    // PRESCALE=2, LOAD=1: IFLAG at +6, W1C, then W1C colliding with a set
    quiesce();
    apb_write(8'h14, 8'h02);
    apb_write(8'h04, 8'h01);
    apb_write(8'h00, 8'h03);
    for (int k = 1; k <= 6; k++) begin
      step();
      check_bit("presc2_iflag", intr, k == 6);
    end
    apb_write(8'h10, 8'h01);
    check_bit("w1c_clears_intr", intr, 1'b0);
    step();
    step();
    apb_write(8'h10, 8'h03);
    check_bit("set_beats_w1c", intr, 1'b1);
    apb_read(8'h10, 8'h01, 0);

    // LOAD written mid-run only affects the next reload
    quiesce();
    apb_write(8'h14, 8'h00);
    apb_write(8'h04, 8'h05);
    apb_write(8'h00, 8'h03);
    step();
    apb_write(8'h04, 8'h10);
    step();
    step();
    apb_read(8'h08, 8'h10, 0);
    apb_read(8'h04, 8'h10, 0);

    // Reset asserted on the commit edge of a LOAD write
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 8'h04; pwdata = 8'h77;
    step();
    penable = 1'b1;
    preset  = 1'b1;
    step();
    preset = 1'b0;
    bus_idle();
    read_reset_values();

    // Randomized traffic against the model
    apb_write(8'h04, 8'h02);
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 10))
        0, 1, 2: apb_read(addrs[$urandom_range(0, 7)], 8'h00, 1);
        3: begin
          d = 8'($urandom);
          d[0] = ($urandom_range(0, 3) != 0);
          apb_write(8'h00, d);
        end
        4: apb_write(8'h04, 8'($urandom_range(0, 6)));
        5, 6: apb_write(8'h0C, ($urandom_range(0, 3) == 0) ? 8'($urandom) : KEY);
        7: apb_write(8'h10, 8'($urandom_range(0, 3)));
        8: begin
          if (!m_en) apb_write(8'h14, 8'($urandom_range(0, 3)));
          else       step();
        end
        9: apb_write(addrs[$urandom_range(6, 7)], 8'($urandom));
        default: repeat ($urandom_range(1, 6)) step();
      endcase
    end

    step();
    step();
    check("reads_all_consumed", 8'(rd_q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
